// File: rtl/pipe_stage_buf.sv
// Registered pipeline stage holding an entry of pc/data/rd. With PIPE_STAGE_BUF_SKID_EN
// defined, a skid register gives a fully registered in_ready; otherwise it is a single-entry stage.
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic [1:0]        occupancy
);

   localparam int ENT_W = 2*DATA_W + RD_W;
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
`ifdef PIPE_STAGE_BUF_SKID_EN
   localparam logic [1:0] FULL  = 2'd2;
`endif

   // State encoding doubles as the entry count.
   logic [1:0]       state_q, state_d;
   logic [ENT_W-1:0] main_q, main_d;
   logic [ENT_W-1:0] in_ent;
   logic             in_fire, out_fire;
`ifdef PIPE_STAGE_BUF_SKID_EN
   logic [ENT_W-1:0] skid_q, skid_d;
`endif

   assign in_ent    = {in_pc, in_data, in_rd};
   assign out_valid = (state_q != EMPTY);
`ifdef PIPE_STAGE_BUF_SKID_EN
   assign in_ready  = (state_q != FULL);
`else
   assign in_ready  = (state_q == EMPTY) | out_ready;
`endif
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign occupancy = state_q;
   assign {out_pc, out_data, out_rd} = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_STAGE_BUF_SKID_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_ent;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_ent;
`ifdef PIPE_STAGE_BUF_SKID_EN
               end else if (in_fire) begin
                  skid_d  = in_ent;
                  state_d = FULL;
`endif
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
`ifdef PIPE_STAGE_BUF_SKID_EN
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
`ifdef PIPE_STAGE_BUF_SKID_EN
         skid_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
`ifdef PIPE_STAGE_BUF_SKID_EN
         skid_q  <= skid_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue model of held entries predicts handshakes,
// occupancy and the head payload; directed scenarios followed by random traffic.
module tb_pipe_stage_buf;
   localparam int DW  = 32;
   localparam int RW  = 6;
   localparam int EW  = 2*DW + RW;
`ifdef PIPE_STAGE_BUF_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_pc;
   logic [DW-1:0] in_data;
   logic [RW-1:0] in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_pc;
   logic [DW-1:0] out_data;
   logic [RW-1:0] out_rd;
   logic [1:0]    occupancy;

   int vectors    = 0;
   int miscompares = 0;
   logic [EW-1:0] exp_q[$];

   pipe_stage_buf #(.DATA_W(DW), .RD_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_data(in_data), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_data(out_data), .out_rd(out_rd),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: predicts this cycle's outputs from the model queue, then applies the coming edge.
   always @(negedge clk) begin
      int cnt;
      logic e_ov, e_ir;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         cnt  = exp_q.size();
         e_ov = (cnt != 0);
         e_ir = (CAP == 2) ? (cnt < 2) : ((cnt == 0) || out_ready);
         chk("out_valid", EW'(out_valid), EW'(e_ov));
         chk("in_ready",  EW'(in_ready),  EW'(e_ir));
         chk("occupancy", EW'(occupancy), EW'(cnt));
         if (e_ov)
            chk("payload", {out_pc, out_data, out_rd}, exp_q[0]);
         if (flush) begin
            exp_q.delete();
         end else begin
            if (e_ov && out_ready) begin
               $display("out  pc=%08h data=%08h rd=%0d", out_pc, out_data, out_rd);
               void'(exp_q.pop_front());
            end
            if (in_valid && e_ir)
               exp_q.push_back({in_pc, in_data, in_rd});
         end
      end
   end

   task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_pc     = $urandom;
      in_rd     = RW'($urandom);
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, EW'(out_valid), '0);
      chk({tag, "_in_ready"},  EW'(in_ready),  EW'(1));
      chk({tag, "_out_data"},  EW'(out_data),  '0);
      chk({tag, "_occupancy"}, EW'(occupancy), '0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_data = '0; in_rd = '0;
      #2;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // streaming
      step(1'b1, 32'h10, 1'b1, 1'b0);
      step(1'b1, 32'h11, 1'b1, 1'b0);
      step(1'b1, 32'h12, 1'b1, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0);

`ifdef PIPE_STAGE_BUF_SKID_EN
      // stall into FULL, then drain
      step(1'b1, 32'hA1, 1'b0, 1'b0);
      step(1'b1, 32'hA2, 1'b0, 1'b0);
      step(1'b1, 32'hA3, 1'b0, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      // flush while FULL with a valid input
      step(1'b1, 32'hB1, 1'b0, 1'b0);
      step(1'b1, 32'hB2, 1'b0, 1'b0);
      step(1'b1, 32'hFF, 1'b0, 1'b1);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      // fill to FULL, then async reset between edges
      step(1'b1, 32'hC1, 1'b0, 1'b0);
      step(1'b1, 32'hC2, 1'b0, 1'b0);
      step(1'b0, 32'h0,  1'b0, 1'b0);
`else
      // stall in ONE, toggling out_ready
      step(1'b1, 32'hA1, 1'b0, 1'b0);
      step(1'b1, 32'hA2, 1'b0, 1'b0);
      step(1'b1, 32'hA2, 1'b1, 1'b0);
      step(1'b1, 32'hA3, 1'b0, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      // flush in ONE with a would-be accepted input
      step(1'b1, 32'hB1, 1'b0, 1'b0);
      step(1'b1, 32'hFF, 1'b1, 1'b1);
      step(1'b0, 32'h0,  1'b1, 1'b0);
      step(1'b1, 32'hC1, 1'b0, 1'b0);
      step(1'b0, 32'h0,  1'b0, 1'b0);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // random traffic
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 7,
              $urandom_range(0, 39) == 0);
      for (int i = 0; i < 4; i++)
         step(1'b0, 32'h0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32: SHALL set the width of the pc and data payload fields.
REQ-002 Parameter RD_W, default 6: SHALL set the width of the destination-register field.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 flush  in  1  SHALL be a synchronous request to discard all held entries.
REQ-006 in_valid  in  1  SHALL mean the upstream payload is valid.
REQ-007 in_ready  out  1  SHALL mean the stage accepts the payload this cycle.
REQ-008 in_pc  in  DATA_W  SHALL carry the upstream PC.
REQ-009 in_data  in  DATA_W  SHALL carry the upstream data or ALU result.
REQ-010 in_rd  in  RD_W  SHALL carry the upstream destination register.
REQ-011 out_valid  out  1  SHALL mean out_pc, out_data and out_rd hold a valid entry.
REQ-012 out_ready  in  1  SHALL mean downstream accepts the entry this cycle (deasserted = stall).
REQ-013 out_pc / out_data / out_rd  out  DATA_W / DATA_W / RD_W  SHALL present the head entry's payload.
REQ-014 occupancy  out  2  SHALL report the held entry count (0..2).

Function
REQ-015 Input fire = in_valid & in_ready; output fire = out_valid & out_ready; payload fields SHALL always move together as one entry.
REQ-016 Storage SHALL be a main register (drives outputs) plus a skid register; states are EMPTY (0 entries), ONE (main), FULL (main+skid).
REQ-017 out_valid SHALL equal (state != EMPTY); in_ready SHALL equal (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-018 EMPTY: input fire SHALL load main -> ONE; otherwise stay EMPTY.
REQ-019 ONE: input+output fire SHALL reload main -> ONE; input fire only SHALL load skid -> FULL; output fire only -> EMPTY; neither -> hold.
REQ-020 FULL: output fire SHALL move skid to main -> ONE; otherwise hold; no input accepted.
REQ-021 Latency SHALL be 1 cycle: an entry accepted at edge N is on the outputs with out_valid=1 after edge N.
REQ-022 While out_valid=1 and out_ready=0, the output payload SHALL stay stable.
REQ-023 Entries SHALL leave in acceptance order; none dropped or duplicated except by flush.
REQ-024 flush=1 SHALL take priority over all fires: next state EMPTY, occupancy 0, same-cycle input discarded; payload registers keep their stale values.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one entry per cycle.

Reset
REQ-026 rst_n=0 SHALL immediately (without waiting for clk) force state EMPTY: out_valid=0, occupancy=0, in_ready=1, out_pc/out_data/out_rd=0, skid register cleared.
REQ-027 The first input fire SHALL be possible on the first clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all entries, with no partial transfer observable.

Configuration
REQ-029 Macro PIPE_STAGE_BUF_SKID_EN defined: the skid register and FULL state SHALL exist as in REQ-016..REQ-020.
REQ-030 Macro undefined: no skid register; in_ready SHALL equal (!out_valid | out_ready) combinationally; FULL is unreachable; occupancy never exceeds 1; all other behaviour is unchanged.

Verification
REQ-031 Reset: rst_n=0 with no clk edges -> out_valid=0, in_ready=1, out_data=0, occupancy=0 immediately.
REQ-032 Streaming: in_valid=1, out_ready=1, in_data=0x10,0x11,0x12 on consecutive edges -> out_data shows 0x10,0x11,0x12 one cycle later, occupancy=1 throughout.
REQ-033 Stall: feed 0xA1 then 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA1; raise out_ready -> 0xA1 then 0xA2 are delivered, and in_ready=1 after the first output fire.
REQ-034 Flush in FULL with in_valid=1 (in_data=0xFF) -> out_valid=0, occupancy=0 next cycle; 0xFF never appears.
REQ-035 Async reset asserted between edges while FULL -> out_valid=0, occupancy=0 immediately; entries are absent after release.
REQ-036 With PIPE_STAGE_BUF_SKID_EN undefined: out_ready=0 while ONE -> in_ready=0 and occupancy stays 1; toggling out_ready -> in_ready follows it in the same cycle.
